// File: rtl/i2c_txn_arbiter_if.sv
// Bundle between two register-access requesters, the transaction arbiter
// and a byte-level i2c_master.
//   reqN_*     : requester command (valid held until reqN_done)
//   reqN_done  : one-cycle completion pulse, rsp_* valid in that cycle
//   m_*        : command to / status from the i2c_master
// slave  : arbiter view (takes requests, drives the i2c_master command)
// master : environment view (requesters plus i2c_master)
interface i2c_txn_arbiter_if;
  logic       req0_valid, req0_rw, req0_done;
  logic [6:0] req0_addr;
  logic [7:0] req0_reg, req0_wdata;
  logic       req1_valid, req1_rw, req1_done;
  logic [6:0] req1_addr;
  logic [7:0] req1_reg, req1_wdata;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       m_ena, m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_busy, m_ack_error;
  logic [7:0] m_rdata;

  modport slave (
    input  req0_valid, req0_rw, req0_addr, req0_reg, req0_wdata,
    input  req1_valid, req1_rw, req1_addr, req1_reg, req1_wdata,
    input  m_busy, m_rdata, m_ack_error,
    output req0_done, req1_done, rsp_rdata, rsp_error,
    output m_ena, m_rw, m_addr, m_wdata
  );

  modport master (
    output req0_valid, req0_rw, req0_addr, req0_reg, req0_wdata,
    output req1_valid, req1_rw, req1_addr, req1_reg, req1_wdata,
    output m_busy, m_rdata, m_ack_error,
    input  req0_done, req1_done, rsp_rdata, rsp_error,
    input  m_ena, m_rw, m_addr, m_wdata
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Two-requester round-robin arbiter that turns one register read/write into
// an i2c_master command sequence: byte 0 = register number (write), byte 1 =
// write data, or a repeated-start read. Progress is tracked by counting
// m_busy edges; a per-edge timeout aborts a stuck sequence.
//   clk48   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : requester / i2c_master bundle (slave modport)
module i2c_txn_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic           clk48,
  input  logic           reset_n,
  i2c_txn_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, BYTE2, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  req_valid;
  logic        do_grant, gnt_sel, busy_rise, tmo_hit;
  logic        busy_q, gnt, rr_last, lat_rw, err_q, m_ena_q, m_rw_q;
  logic [7:0]  lat_wdata, m_wdata_q, rdata_q;
  logic [6:0]  m_addr_q;
  logic [1:0]  done_q;
  logic [31:0] tmo_cnt;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign busy_rise = bus.m_busy & ~busy_q;
  // Fires on the cycle the counter would reach the limit, so m_ena is
  // high for exactly TIMEOUT_CYCLES cycles when the master never answers.
  assign tmo_hit   = (tmo_cnt + 32'd1 == TIMEOUT_CYCLES);

  always_ff @(posedge clk48 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    gnt_sel   = 1'b0;
    case (state)
      IDLE:
        if (|req_valid && !bus.m_busy) begin
          do_grant  = 1'b1;
          // both pending: serve the one not served last
          gnt_sel   = (&req_valid) ? ~rr_last : req_valid[1];
          state_nxt = BYTE0;
        end
      BYTE0:   if (busy_rise) state_nxt = BYTE1;
               else if (tmo_hit) state_nxt = DRAIN;
      BYTE1:   if (busy_rise) state_nxt = BYTE2;
               else if (tmo_hit) state_nxt = DRAIN;
      BYTE2:   if (!bus.m_busy) state_nxt = DONE;
               else if (tmo_hit) state_nxt = DRAIN;
      DRAIN:   if (!bus.m_busy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= 1'b0;
      gnt       <= 1'b0;
      rr_last   <= 1'b1;   // "last served = 1" gives requester 0 priority
      lat_rw    <= 1'b0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
      m_ena_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      done_q    <= '0;
      tmo_cnt   <= '0;
    end else begin
      busy_q <= bus.m_busy;
      done_q <= 2'b00;
      if (state inside {BYTE0, BYTE1, BYTE2, DRAIN}) begin
        tmo_cnt <= tmo_cnt + 32'd1;
        if (bus.m_ack_error) err_q <= 1'b1;
      end
      if (do_grant) begin
        gnt       <= gnt_sel;
        rr_last   <= gnt_sel;
        lat_rw    <= gnt_sel ? bus.req1_rw    : bus.req0_rw;
        lat_wdata <= gnt_sel ? bus.req1_wdata : bus.req0_wdata;
        m_addr_q  <= gnt_sel ? bus.req1_addr  : bus.req0_addr;
        m_wdata_q <= gnt_sel ? bus.req1_reg   : bus.req0_reg;
        m_rw_q    <= 1'b0;
        m_ena_q   <= 1'b1;
        err_q     <= 1'b0;
        tmo_cnt   <= '0;
      end
      // first byte accepted: queue write data, or flip rw for a
      // repeated-start read
      if (state == BYTE0 && state_nxt == BYTE1) begin
        tmo_cnt <= '0;
        m_rw_q  <= lat_rw;
        if (!lat_rw) m_wdata_q <= lat_wdata;
      end
      // second byte accepted: dropping ena makes the master stop after it
      if (state == BYTE1 && state_nxt == BYTE2) begin
        tmo_cnt <= '0;
        m_ena_q <= 1'b0;
      end
      if (state != DRAIN && state_nxt == DRAIN) begin
        m_ena_q <= 1'b0;
        err_q   <= 1'b1;
      end
      if (state != DONE && state_nxt == DONE) begin
        tmo_cnt <= '0;
        if (lat_rw) rdata_q <= bus.m_rdata;
        done_q  <= gnt ? 2'b10 : 2'b01;
      end
    end
  end

  assign bus.req0_done = done_q[0];
  assign bus.req1_done = done_q[1];
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
  assign bus.m_ena     = m_ena_q;
  assign bus.m_rw      = m_rw_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;

endmodule
